// File: rtl/fifo_tx_pkg.sv
// Shared types and line levels for the FIFO-draining serial transmitter.
package fifo_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } tx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/fifo_tx_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 while enabled and pulses tick_c on the last count.
module fifo_tx_bit_timer #(
    parameter int unsigned BIT_CYCLES  = 4,
    parameter int unsigned TIMER_WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic tick_c
);

    localparam logic [TIMER_WIDTH-1:0] LAST_COUNT = TIMER_WIDTH'(BIT_CYCLES - 1);

    logic [TIMER_WIDTH-1:0] count_q;
    logic [TIMER_WIDTH-1:0] count_d;

    assign tick_c = count_en && (count_q == LAST_COUNT);

    // Next count: clear wins, otherwise advance and wrap at the period end.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en) begin
            count_d = tick_c ? '0 : count_q + TIMER_WIDTH'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from the put/get FIFO and sends each as start, LSB-first data, stop on tx_serial.
module fifo_serial_tx
    import fifo_tx_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned BIT_CYCLES   = 4,
    parameter int unsigned TIMER_WIDTH  = 8,
    parameter int unsigned BITCNT_WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fifo_empty_bar,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_get,
    output logic             tx_serial,
    output logic             tx_busy,
    output logic [15:0]      frame_count
);

    localparam logic [BITCNT_WIDTH-1:0] LAST_BIT = BITCNT_WIDTH'(WIDTH - 1);

    tx_state_t             state_q;
    tx_state_t             state_d;
    logic [WIDTH-1:0]      shift_q;
    logic [WIDTH-1:0]      shift_d;
    logic [BITCNT_WIDTH-1:0] bit_cnt_q;
    logic [BITCNT_WIDTH-1:0] bit_cnt_d;
    logic                  tx_serial_q;
    logic                  tx_serial_d;
    logic                  fifo_get_q;
    logic                  fifo_get_d;
    logic                  tx_busy_q;
    logic                  tx_busy_d;
    logic [15:0]           frame_count_q;
    logic [15:0]           frame_count_d;

    logic                  timer_clear_c;
    logic                  timer_en_c;
    logic                  bit_tick_c;

    // The timer restarts at LOAD so the start bit gets a full period.
    assign timer_clear_c = (state_q == LOAD);
    assign timer_en_c    = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    fifo_tx_bit_timer #(
        .BIT_CYCLES  (BIT_CYCLES),
        .TIMER_WIDTH (TIMER_WIDTH)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear_c),
        .count_en (timer_en_c),
        .tick_c   (bit_tick_c)
    );

    // Next-state and next-output logic; every output is taken from a flop.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        tx_serial_d   = tx_serial_q;
        fifo_get_d    = 1'b0;
        tx_busy_d     = tx_busy_q;
        frame_count_d = frame_count_q;

        case (state_q)
            IDLE: begin
                tx_serial_d = LINE_IDLE;
                tx_busy_d   = 1'b0;
                if (enable && fifo_empty_bar) begin
                    state_d    = POP;
                    fifo_get_d = 1'b1;
                    tx_busy_d  = 1'b1;
                end
            end
            POP: begin
                // fifo_data becomes valid in the cycle after the pop pulse.
                state_d = LOAD;
            end
            LOAD: begin
                shift_d     = fifo_data;
                bit_cnt_d   = '0;
                tx_serial_d = LINE_START;
                state_d     = START;
            end
            START: begin
                if (bit_tick_c) begin
                    tx_serial_d = shift_q[0];
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (bit_tick_c) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d   = '0;
                        tx_serial_d = LINE_STOP;
                        state_d     = STOP;
                    end else begin
                        bit_cnt_d   = bit_cnt_q + BITCNT_WIDTH'(1);
                        tx_serial_d = shift_d[0];
                    end
                end
            end
            STOP: begin
                if (bit_tick_c) begin
                    frame_count_d = frame_count_q + 16'(1);
                    tx_busy_d     = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                tx_serial_d = LINE_IDLE;
                tx_busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            tx_serial_q   <= LINE_IDLE;
            fifo_get_q    <= 1'b0;
            tx_busy_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_serial_q   <= tx_serial_d;
            fifo_get_q    <= fifo_get_d;
            tx_busy_q     <= tx_busy_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign fifo_get    = fifo_get_q;
    assign tx_serial   = tx_serial_q;
    assign tx_busy     = tx_busy_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Scoreboard bench: a FIFO model feeds the DUT, a line monitor rebuilds each frame and compares.
module tb_fifo_serial_tx;

    localparam int unsigned W     = 16;
    localparam int unsigned BC    = 4;
    localparam int unsigned FRAME = (W + 2) * BC;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          fifo_empty_bar;
    logic [W-1:0]  fifo_data;
    logic          fifo_get;
    logic          tx_serial;
    logic          tx_busy;
    logic [15:0]   frame_count;

    logic [W-1:0]  fifo_q[$];
    logic [W-1:0]  exp_q[$];
    int            gap_q[$];

    int            n_checks;
    int            n_fail;
    int            cyc;
    int            get_count;
    int            underflow;
    int            frames_done;
    int            mon_pos;
    int            gap_cnt;
    int            last_get_cyc;
    int            last_start_cyc;
    bit            mon_active;
    logic [FRAME-1:0] mon_bits;
    logic [W-1:0]  cur_exp;

    always #5 clk = ~clk;

    fifo_serial_tx #(
        .WIDTH        (W),
        .BIT_CYCLES   (BC),
        .TIMER_WIDTH  (8),
        .BITCNT_WIDTH (5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .fifo_empty_bar (fifo_empty_bar),
        .fifo_data      (fifo_data),
        .fifo_get       (fifo_get),
        .tx_serial      (tx_serial),
        .tx_busy        (tx_busy),
        .frame_count    (frame_count)
    );

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected line level for every cycle of one frame carrying word w.
    function automatic logic [FRAME-1:0] exp_wave(input logic [W-1:0] w);
        logic [FRAME-1:0] v;
        v = '0;
        for (int i = 0; i < int'(FRAME); i++) begin
            if (i < int'(BC))
                v[i] = 1'b0;
            else if (i < int'((W + 1) * BC))
                v[i] = w[(i - int'(BC)) / int'(BC)];
            else
                v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic finish_frame();
        logic [W-1:0] rx;
        rx = '0;
        for (int b = 0; b < int'(W); b++)
            rx[b] = mon_bits[int'(BC) * (b + 1) + int'(BC) / 2];
        check("rx_word", 96'(rx), 96'(cur_exp));
        check("frame_wave", 96'(mon_bits), 96'(exp_wave(cur_exp)));
        mon_active = 1'b0;
        gap_cnt    = 0;
        frames_done++;
    endtask

    // One clock: sample at the falling edge, run the FIFO model and the line monitor.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (fifo_get) begin
            get_count++;
            last_get_cyc = cyc;
            if (fifo_q.size() == 0) underflow++;
            else fifo_data = fifo_q.pop_front();
        end
        fifo_empty_bar = (fifo_q.size() != 0);
        if (reset) begin
            mon_active = 1'b0;
            gap_cnt    = 0;
        end else if (mon_active) begin
            mon_bits[mon_pos] = tx_serial;
            mon_pos++;
            if (mon_pos == int'(FRAME)) finish_frame();
        end else if (tx_serial == 1'b0) begin
            mon_active     = 1'b1;
            mon_bits       = '0;
            mon_pos        = 1;
            last_start_cyc = cyc;
            gap_q.push_back(gap_cnt);
            check("frame_expected", 96'(exp_q.size() != 0), 96'(1));
            cur_exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        end else begin
            gap_cnt++;
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty_bar = 1'b1;
    endtask

    task automatic wait_frames(input int target);
        int budget;
        budget = 0;
        while (frames_done < target && budget < 1000) begin
            step();
            budget++;
        end
        check("frame_timeout", 96'(frames_done >= target), 96'(1));
    endtask

    initial begin
        int c0;
        n_checks = 0; n_fail = 0; cyc = 0; get_count = 0; underflow = 0;
        frames_done = 0; mon_pos = 0; gap_cnt = 0; last_get_cyc = 0; last_start_cyc = 0;
        mon_active = 1'b0; mon_bits = '0; cur_exp = '0;
        reset = 1'b1; enable = 1'b1; fifo_empty_bar = 1'b0; fifo_data = '0;

        // Reset, then idle with an empty FIFO.
        step(); step();
        check("rst_state", 96'({tx_serial, fifo_get, tx_busy, frame_count}), 96'({1'b1, 1'b0, 1'b0, 16'h0000}));
        reset = 1'b0;
        repeat (50) begin
            step();
            check("idle_empty", 96'({tx_serial, fifo_get, tx_busy, frame_count}), 96'({1'b1, 1'b0, 1'b0, 16'h0000}));
        end

        // Single word with latency checks.
        c0 = cyc;
        push_word(16'hA5C3);
        wait_frames(1);
        step(); step();
        check("get_latency", 96'(last_get_cyc - c0), 96'(1));
        check("start_latency", 96'(last_start_cyc - c0), 96'(3));
        check("count_1", 96'(frame_count), 96'(16'd1));
        check("gets_1", 96'(get_count), 96'(1));
        check("busy_after_1", 96'(tx_busy), 96'(0));

        // Three queued words back to back.
        push_word(16'h0001);
        push_word(16'h8000);
        push_word(16'hFFFF);
        wait_frames(4);
        step(); step();
        check("gap_2", 96'(gap_q[gap_q.size() - 2]), 96'(3));
        check("gap_3", 96'(gap_q[gap_q.size() - 1]), 96'(3));
        check("count_4", 96'(frame_count), 96'(16'd4));
        check("gets_4", 96'(get_count), 96'(4));

        // Enable dropped mid-frame: frame completes, no new pop until re-enabled.
        push_word(16'h1234);
        for (int i = 0; i < 200 && !(mon_active && mon_pos >= int'(5 * BC)); i++) step();
        enable = 1'b0;
        push_word(16'h5555);
        wait_frames(5);
        repeat (20) step();
        check("gets_disabled", 96'(get_count), 96'(5));
        check("count_5", 96'(frame_count), 96'(16'd5));
        check("busy_disabled", 96'(tx_busy), 96'(0));
        c0 = cyc;
        enable = 1'b1;
        step();
        check("reenable_get", 96'(last_get_cyc - c0), 96'(1));
        wait_frames(6);

        // Reset during the fifth data bit; the popped word is dropped.
        push_word(16'h0F0F);
        push_word(16'h3C3C);
        for (int i = 0; i < 300 && !(mon_active && mon_pos == int'(5 * BC + 1)); i++) step();
        check("gets_pre_rst", 96'(get_count), 96'(7));
        reset = 1'b1;
        step();
        check("rst_mid", 96'({tx_serial, tx_busy, fifo_get, frame_count}), 96'({1'b1, 1'b0, 1'b0, 16'h0000}));
        reset = 1'b0;
        wait_frames(7);
        step(); step();
        check("gets_post_rst", 96'(get_count), 96'(8));
        check("count_post_rst", 96'(frame_count), 96'(16'd1));

        // Frame counter wrap from 16'hFFFF.
        force dut.frame_count_q = 16'hFFFF;
        step(); step();
        release dut.frame_count_q;
        step();
        check("pre_wrap", 96'(frame_count), 96'(16'hFFFF));
        push_word(16'h7E81);
        wait_frames(8);
        step(); step();
        check("wrap", 96'(frame_count), 96'(16'h0000));
        check("gets_wrap", 96'(get_count), 96'(9));

        check("no_underflow", 96'(underflow), 96'(0));
        check("scoreboard_empty", 96'(exp_q.size()), 96'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
Drain-side consumer for the team's 16-bit put/get FIFO. It pops one word whenever the FIFO reports non-empty and transmission is enabled. It then serializes the word onto a single-wire line framed as start bit, WIDTH data bits LSB-first, then stop bit. It sits between the FIFO read port and the chip-level serial output pin.

Parameters:
WIDTH, 16, data word width; matches FIFO data width
BIT_CYCLES, 4, clk cycles each serial bit is held (>=2)
TIMER_WIDTH, 8, width of bit-period counter; 2^TIMER_WIDTH > BIT_CYCLES
BITCNT_WIDTH, 5, width of data-bit counter; 2^BITCNT_WIDTH > WIDTH

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  reset, synchronous, active-high
enable  input  1  permits starting a new frame; sampled in IDLE only
fifo_empty_bar  input  1  FIFO non-empty flag (1 = at least one word)
fifo_data  input  WIDTH  FIFO read data; valid the cycle after an accepted get
fifo_get  output  1  one-cycle pop request to FIFO
tx_serial  output  1  serial line; idles high
tx_busy  output  1  high from pop through end of stop bit
frame_count  output  16  count of completed frames

Behaviour:
- All outputs registered. Reset values: tx_serial=1, fifo_get=0, tx_busy=0, frame_count=0, state=IDLE, counters=0, shift register=0.
- FIFO read semantics (decided): fifo_get high for one cycle pops a word. fifo_data holds that word from the following cycle onward.
- States: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE: tx_serial=1, tx_busy=0. If enable && fifo_empty_bar, go to POP.
- POP: fifo_get=1 for exactly this cycle, tx_busy=1, then go to LOAD.
- LOAD: fifo_get=0. Capture fifo_data into shift register. Drive tx_serial=0. Clear bit timer. Go to START.
- START: hold tx_serial=0 for BIT_CYCLES cycles, then drive shift_reg[0] and go to DATA.
- DATA: each bit held BIT_CYCLES cycles. At period end, shift right and increment bit counter. After WIDTH bits, drive tx_serial=1 and go to STOP.
- STOP: hold 1 for BIT_CYCLES cycles. At end: frame_count += 1 (wraps 16'hFFFF -> 0), tx_busy=0, go to IDLE.
- Latency: condition true in IDLE at cycle N -> fifo_get=1 in cycle N+1 -> start bit on tx_serial from cycle N+3.
- Frame length is (WIDTH+2)*BIT_CYCLES cycles of tx_serial activity.
- Back-to-back: with FIFO still non-empty, the line stays high for exactly 3 cycles between stop-bit end and next start bit (IDLE, POP, LOAD).
- Exactly one fifo_get per frame. fifo_get never asserts unless fifo_empty_bar=1 was sampled in IDLE.
- enable or fifo_empty_bar changing outside IDLE is ignored; an in-flight frame always completes.
- fifo_empty_bar=0 in IDLE: stay in IDLE indefinitely, no get.
- Reset mid-frame: next cycle tx_serial=1, state IDLE. The popped word is discarded, not re-requested. frame_count clears.
- Bit timer counts 0..BIT_CYCLES-1; its period-end pulse advances START/DATA/STOP.

Decomposition:
- Package fifo_tx_pkg: typedef enum for tx_state_t (IDLE, POP, LOAD, START, DATA, STOP); localparams for idle line level (1), start level (0), stop level (1).
- One sub-module: fifo_tx_bit_timer. It takes clk, reset, clear, and count enable; outputs a one-cycle tick at count BIT_CYCLES-1, then wraps to 0.

Test Plan:
- Reset then idle: reset 2 cycles, FIFO empty, enable=1 -> tx_serial=1, fifo_get=0, tx_busy=0, frame_count=0 for 50 cycles.
- Single word 16'hA5C3, BIT_CYCLES=4 -> fifo_get pulses once. The line shows 0 for 4 cycles, then bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4. Total 72 cycles; frame_count=1.
- Three queued words 16'h0001, 16'h8000, 16'hFFFF -> three frames, each separated by exactly 3 high cycles. Serial bits match LSB-first order; frame_count=3; exactly 3 get pulses.
- enable dropped mid-DATA of word 16'h1234 -> frame completes, no further get while enable=0. Re-asserting enable starts the next pop within 1 cycle.
- Reset asserted in DATA, 5th bit -> tx_serial=1 and tx_busy=0 on the next cycle. No get for the lost word; the next FIFO word is transmitted cleanly after reset release.
- Wrap: preload frame_count path by sending 65536 frames (or force) -> frame_count wraps 16'hFFFF -> 16'h0000.
